game_ctrl: RTL and testbench

Top-level game sequencer for the whack-a-mole design. It sits upstream of the screen renderers (title, play field, win screen) and the mole logic. It turns the start button and hit pulses into a game state, a score and a countdown. Its registered outputs select which screen drives the VGA pins, and they feed the score and time text to the character generators.

---
 rtl/game_pkg.sv | 38 +++
 rtl/game_ctrl_if.sv | 36 +++
 rtl/tick_gen.sv | 41 ++++
 rtl/game_ctrl.sv | 133 +++++++++++++
 tb/tb_game_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared definitions for the whack-a-mole game sequencer and its consumers.
//   screen_e   : state / screen-select encoding, also decoded by the VGA mux
//   SCORE_MAX  : score saturation point (decimal 99)
//   to_bcd8    : constant-friendly binary -> two-digit packed BCD conversion
//   bin_inc    : saturating binary score increment
//   bcd_inc    : saturating packed-BCD score increment
// ---------------------------------------------------------------------------
package game_pkg;

  typedef enum logic [1:0] {
    SCR_TITLE = 2'd0,
    SCR_PLAY  = 2'd1,
    SCR_WIN   = 2'd2,
    SCR_LOSE  = 2'd3
  } screen_e;

  localparam int unsigned SCORE_MAX = 99;

  // Valid for v in 0..99.
  function automatic logic [7:0] to_bcd8(input int unsigned v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [7:0] bin_inc(input logic [7:0] s);
    if (s >= 8'(SCORE_MAX)) return s;
    return s + 8'd1;
  endfunction

  // Ones digit wraps 9 -> 0 with a carry into the tens digit.
  function automatic logic [7:0] bcd_inc(input logic [7:0] s);
    if (s >= to_bcd8(SCORE_MAX)) return s;
    if (s[3:0] == 4'd9) return {s[7:4] + 4'd1, 4'd0};
    return {s[7:4], s[3:0] + 4'd1};
  endfunction

endpackage

// File: rtl/game_ctrl_if.sv
// ---------------------------------------------------------------------------
// game_ctrl_if
// Bundle between the game sequencer and its surroundings.
//   start      : debounced start button level (into the sequencer)
//   hit        : one-cycle whack pulse from the mole logic (into the sequencer)
//   screen     : screen select for the VGA mux
//   mole_en    : mole spawning enable, high only while playing
//   score      : hits this round (binary or packed BCD, see game_ctrl)
//   time_left  : seconds remaining in the round, binary
//   win_pulse  : one-cycle pulse on PLAY -> WIN
//   lose_pulse : one-cycle pulse on PLAY -> LOSE
// Modports: master = game_ctrl side, slave = the driving / observing side.
// ---------------------------------------------------------------------------
interface game_ctrl_if;
  import game_pkg::*;

  logic       start;
  logic       hit;
  screen_e    screen;
  logic       mole_en;
  logic [7:0] score;
  logic [6:0] time_left;
  logic       win_pulse;
  logic       lose_pulse;

  modport master (
    input  start, hit,
    output screen, mole_en, score, time_left, win_pulse, lose_pulse
  );

  modport slave (
    output start, hit,
    input  screen, mole_en, score, time_left, win_pulse, lose_pulse
  );

endinterface

// File: rtl/tick_gen.sv
// ---------------------------------------------------------------------------
// tick_gen
// One-second prescaler: counts 0..CLK_HZ-1 while enabled and raises tick for
// the single cycle in which the count sits at its terminal value.
//   clk   : system clock
//   reset : asynchronous active-low reset
//   clr   : synchronous clear, overrides en
//   en    : count enable
//   tick  : one-cycle pulse once every CLK_HZ enabled cycles
// Parameter: CLK_HZ, cycles per tick.
// ---------------------------------------------------------------------------
module tick_gen #(
  parameter int unsigned CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] TERM = CW'(CLK_HZ - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == TERM);

  always_comb begin
    cnt_d = cnt_q;
    if (clr)       cnt_d = '0;
    else if (tick) cnt_d = '0;
    else if (en)   cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/game_ctrl.sv
// ---------------------------------------------------------------------------
// game_ctrl
// Whack-a-mole game sequencer: TITLE -> PLAY -> WIN/LOSE -> TITLE.
// Turns the start button and hit pulses into the screen select, the score,
// the round countdown and win/lose pulses. All bus outputs are registered.
//   clk   : system clock (single domain)
//   reset : asynchronous active-low reset
//   bus   : game_ctrl_if.master (start, hit in; screen, mole_en, score,
//           time_left, win_pulse, lose_pulse out)
// Build option: define GAME_CTRL_BCD_EN to present score as two packed BCD
// digits {tens, ones}; otherwise score is plain binary. Both saturate at 99.
// ---------------------------------------------------------------------------
module game_ctrl
  import game_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 100_000_000,
  parameter int unsigned GAME_SECONDS = 30,
  parameter int unsigned WIN_SCORE    = 10,
  parameter int unsigned HOLD_SECONDS = 5
) (
  input  logic         clk,
  input  logic         reset,
  game_ctrl_if.master  bus
);

  localparam int unsigned HOLD_W = $clog2(HOLD_SECONDS + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_SECONDS - 1);

  screen_e           state_q, state_d;
  logic              start_q;
  logic [7:0]        score_q, score_d;
  logic [6:0]        time_q, time_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              mole_en_q;
  logic              win_q, lose_q;

  logic              start_rise;
  logic              state_chg;
  logic              tick;
  logic [7:0]        score_inc;

`ifdef GAME_CTRL_BCD_EN
  localparam logic [7:0] WIN_CODE = to_bcd8(WIN_SCORE);
  assign score_inc = bcd_inc(score_q);
`else
  localparam logic [7:0] WIN_CODE = 8'(WIN_SCORE);
  assign score_inc = bin_inc(score_q);
`endif

  assign start_rise = bus.start & ~start_q;

  // One prescaler serves both the round countdown and the end-screen hold;
  // clearing it on every state change restarts each second from entry.
  tick_gen #(
    .CLK_HZ (CLK_HZ)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (state_chg),
    .en    (state_q != SCR_TITLE),
    .tick  (tick)
  );

  always_comb begin
    state_d = state_q;
    score_d = score_q;
    time_d  = time_q;
    hold_d  = hold_q;

    case (state_q)
      SCR_TITLE: begin
        if (start_rise) begin
          state_d = SCR_PLAY;
          score_d = '0;
          time_d  = 7'(GAME_SECONDS);
        end
      end

      SCR_PLAY: begin
        if (bus.hit) score_d = score_inc;
        // The countdown still runs on the final tick even when a hit wins
        // in the same cycle; the win simply takes priority over the loss.
        if (tick && (time_q != '0)) time_d = time_q - 7'd1;
        if (bus.hit && (score_inc == WIN_CODE)) state_d = SCR_WIN;
        else if (tick && (time_q == 7'd1))      state_d = SCR_LOSE;
      end

      SCR_WIN, SCR_LOSE: begin
        if (start_rise) begin
          state_d = SCR_TITLE;
        end else if (tick) begin
          if (hold_q == HOLD_LAST) state_d = SCR_TITLE;
          else                     hold_d  = hold_q + HOLD_W'(1);
        end
      end

      default: state_d = SCR_TITLE;
    endcase

    state_chg = (state_d != state_q);
    if (state_chg) hold_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= SCR_TITLE;
      start_q   <= 1'b0;
      score_q   <= '0;
      time_q    <= '0;
      hold_q    <= '0;
      mole_en_q <= 1'b0;
      win_q     <= 1'b0;
      lose_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      start_q   <= bus.start;
      score_q   <= score_d;
      time_q    <= time_d;
      hold_q    <= hold_d;
      mole_en_q <= (state_d == SCR_PLAY);
      win_q     <= (state_q == SCR_PLAY) && (state_d == SCR_WIN);
      lose_q    <= (state_q == SCR_PLAY) && (state_d == SCR_LOSE);
    end
  end

  assign bus.screen     = state_q;
  assign bus.mole_en    = mole_en_q;
  assign bus.score      = score_q;
  assign bus.time_left  = time_q;
  assign bus.win_pulse  = win_q;
  assign bus.lose_pulse = lose_q;

endmodule

// File: tb/tb_game_ctrl.sv
// ---------------------------------------------------------------------------
// tb_game_ctrl
// Two sequencers share clock and reset: dut_a (CLK_HZ=10, 3 s rounds, win at
// 4, 2 s hold) and dut_b (win at 99, 99 s rounds) for score saturation.
// Stimulus pushes cycle-stamped expectations into a queue; a monitor on the
// falling edge pops and compares every entry due in that cycle.
// ---------------------------------------------------------------------------
module tb_game_ctrl;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  game_ctrl_if ifa ();
  game_ctrl_if ifb ();

  game_ctrl #(
    .CLK_HZ (10), .GAME_SECONDS (3), .WIN_SCORE (4), .HOLD_SECONDS (2)
  ) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ifa)
  );

  game_ctrl #(
    .CLK_HZ (10), .GAME_SECONDS (99), .WIN_SCORE (99), .HOLD_SECONDS (2)
  ) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ifb)
  );

  typedef enum int {F_SCREEN, F_MOLE, F_SCORE, F_TIME, F_WIN, F_LOSE} fld_e;

  typedef struct {
    int    cyc;
    int    dut;
    fld_e  fld;
    int    val;
    string tag;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   wins_a = 0, loses_a = 0, wins_b = 0;
  int   mon_act;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int get_val(input int d, input fld_e f);
    if (d == 0) begin
      case (f)
        F_SCREEN: return int'(ifa.screen);
        F_MOLE:   return int'(ifa.mole_en);
        F_SCORE:  return int'(ifa.score);
        F_TIME:   return int'(ifa.time_left);
        F_WIN:    return int'(ifa.win_pulse);
        default:  return int'(ifa.lose_pulse);
      endcase
    end
    case (f)
      F_SCREEN: return int'(ifb.screen);
      F_MOLE:   return int'(ifb.mole_en);
      F_SCORE:  return int'(ifb.score);
      F_TIME:   return int'(ifb.time_left);
      F_WIN:    return int'(ifb.win_pulse);
      default:  return int'(ifb.lose_pulse);
    endcase
  endfunction

  // Expected score encoding after n hits.
  function automatic int exp_score(input int n);
`ifdef GAME_CTRL_BCD_EN
    return ((n / 10) << 4) | (n % 10);
`else
    return n;
`endif
  endfunction

  task automatic expect_at(input int c, input int d, input fld_e f,
                           input int v, input string tag);
    exp_t e;
    e.cyc = c;
    e.dut = d;
    e.fld = f;
    e.val = v;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: compares every expectation due this cycle, away from the edge.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        mon_act = get_val(sb[i].dut, sb[i].fld);
        checks++;
        if (sb[i].cyc < cyc) begin
          errors++;
          $display("FAIL %s: due at cycle %0d, not checked until %0d",
                   sb[i].tag, sb[i].cyc, cyc);
        end else if (mon_act != sb[i].val) begin
          errors++;
          $display("FAIL %s @%0d: got %0d, expected %0d",
                   sb[i].tag, cyc, mon_act, sb[i].val);
        end else begin
          $display("ok   %s @%0d: %0d", sb[i].tag, cyc, mon_act);
        end
        sb.delete(i);
      end
    end
    if (ifa.win_pulse === 1'b1)  wins_a++;
    if (ifa.lose_pulse === 1'b1) loses_a++;
    if (ifb.win_pulse === 1'b1)  wins_b++;
  end

  task automatic final_check(input string tag, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, req);
    end else begin
      $display("ok   %s: %0d", tag, act);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int e0;

  initial begin
    reset     = 1'b0;
    ifa.start = 1'b0;
    ifa.hit   = 1'b0;
    ifb.start = 1'b0;
    ifb.hit   = 1'b0;
    step(2);

    // Reset state
    expect_at(cyc + 1, 0, F_SCREEN, 0, "rst_screen");
    expect_at(cyc + 1, 0, F_MOLE,   0, "rst_mole");
    expect_at(cyc + 1, 0, F_SCORE,  0, "rst_score");
    expect_at(cyc + 1, 0, F_TIME,   0, "rst_time");
    expect_at(cyc + 1, 0, F_WIN,    0, "rst_win");
    expect_at(cyc + 1, 0, F_LOSE,   0, "rst_lose");
    expect_at(cyc + 1, 1, F_SCREEN, 0, "rst_b_screen");
    reset = 1'b1;
    step(2);

    // Win path: four hits three cycles apart, then a full hold back to TITLE
    ifa.start = 1'b1;
    e0 = cyc + 1;
    expect_at(e0,      0, F_SCREEN, 1, "win_entry_screen");
    expect_at(e0,      0, F_MOLE,   1, "win_entry_mole");
    expect_at(e0,      0, F_TIME,   3, "win_entry_time");
    expect_at(e0,      0, F_SCORE,  0, "win_entry_score");
    expect_at(e0 + 2,  0, F_SCORE,  1, "win_score1");
    expect_at(e0 + 5,  0, F_SCORE,  2, "win_score2");
    expect_at(e0 + 8,  0, F_SCORE,  3, "win_score3");
    expect_at(e0 + 9,  0, F_TIME,   3, "win_time_pre_tick");
    expect_at(e0 + 10, 0, F_TIME,   2, "win_time_tick1");
    expect_at(e0 + 10, 0, F_SCREEN, 1, "win_still_play");
    expect_at(e0 + 11, 0, F_SCORE,  4, "win_score4");
    expect_at(e0 + 11, 0, F_SCREEN, 2, "win_screen");
    expect_at(e0 + 11, 0, F_WIN,    1, "win_pulse");
    expect_at(e0 + 11, 0, F_MOLE,   0, "win_mole_off");
    expect_at(e0 + 11, 0, F_TIME,   2, "win_time_frozen");
    expect_at(e0 + 12, 0, F_WIN,    0, "win_pulse_single");
    expect_at(e0 + 30, 0, F_SCREEN, 2, "hold_win_19");
    expect_at(e0 + 31, 0, F_SCREEN, 0, "hold_win_title");
    expect_at(e0 + 31, 0, F_SCORE,  4, "title_keeps_score");
    step(1);
    ifa.start = 1'b0;
    step(1);
    for (int k = 0; k < 4; k++) begin
      ifa.hit = 1'b1;
      step(1);
      ifa.hit = 1'b0;
      step(2);
    end
    step(e0 + 32 - cyc);
    ifa.hit = 1'b1;  // ignored in TITLE
    expect_at(cyc + 1, 0, F_SCORE,  4, "title_hit_ignored");
    expect_at(cyc + 1, 0, F_SCREEN, 0, "title_hit_screen");
    step(1);
    ifa.hit = 1'b0;
    step(1);

    // Timeout: no hits, then abort the LOSE hold with start
    ifa.start = 1'b1;
    e0 = cyc + 1;
    expect_at(e0,      0, F_SCORE,  0, "to_score_cleared");
    expect_at(e0,      0, F_SCREEN, 1, "to_screen_play");
    expect_at(e0,      0, F_TIME,   3, "to_time3");
    expect_at(e0 + 9,  0, F_TIME,   3, "to_time3_end");
    expect_at(e0 + 10, 0, F_TIME,   2, "to_time2");
    expect_at(e0 + 20, 0, F_TIME,   1, "to_time1");
    expect_at(e0 + 29, 0, F_SCREEN, 1, "to_still_play");
    expect_at(e0 + 29, 0, F_LOSE,   0, "to_lose_early");
    expect_at(e0 + 30, 0, F_TIME,   0, "to_time0");
    expect_at(e0 + 30, 0, F_SCREEN, 3, "to_screen_lose");
    expect_at(e0 + 30, 0, F_LOSE,   1, "to_lose_pulse");
    expect_at(e0 + 30, 0, F_MOLE,   0, "to_mole_off");
    expect_at(e0 + 31, 0, F_LOSE,   0, "to_lose_single");
    expect_at(e0 + 35, 0, F_SCREEN, 3, "abort_lose_hold");
    expect_at(e0 + 36, 0, F_SCREEN, 0, "abort_lose_title");
    step(1);
    ifa.start = 1'b0;
    step(e0 + 35 - cyc);
    ifa.start = 1'b1;
    step(1);
    ifa.start = 1'b0;
    step(2);

    // Simultaneous final tick and winning hit, then abort the WIN hold
    ifa.start = 1'b1;
    e0 = cyc + 1;
    expect_at(e0 + 3,  0, F_SCORE,  3, "sim_score3");
    expect_at(e0 + 29, 0, F_TIME,   1, "sim_time1");
    expect_at(e0 + 30, 0, F_SCREEN, 2, "sim_screen_win");
    expect_at(e0 + 30, 0, F_SCORE,  4, "sim_score4");
    expect_at(e0 + 30, 0, F_TIME,   0, "sim_time0");
    expect_at(e0 + 30, 0, F_WIN,    1, "sim_win_pulse");
    expect_at(e0 + 30, 0, F_LOSE,   0, "sim_no_lose");
    expect_at(e0 + 31, 0, F_LOSE,   0, "sim_no_lose_after");
    expect_at(e0 + 31, 0, F_WIN,    0, "sim_win_single");
    expect_at(e0 + 35, 0, F_SCREEN, 2, "abort_win_hold");
    expect_at(e0 + 36, 0, F_SCREEN, 0, "abort_win_title");
    expect_at(e0 + 36, 0, F_SCORE,  4, "abort_win_score");
    step(1);
    ifa.start = 1'b0;
    ifa.hit   = 1'b1;
    step(3);
    ifa.hit   = 1'b0;
    step(e0 + 29 - cyc);
    ifa.hit   = 1'b1;
    step(1);
    ifa.hit   = 1'b0;
    step(e0 + 35 - cyc);
    ifa.start = 1'b1;
    step(1);
    ifa.start = 1'b0;
    step(2);

    // Asynchronous reset mid-round with time_left == 2
    ifa.start = 1'b1;
    e0 = cyc + 1;
    expect_at(e0 + 12, 0, F_SCORE,  1, "pre_rst_score");
    expect_at(e0 + 13, 0, F_TIME,   2, "pre_rst_time");
    expect_at(e0 + 13, 0, F_SCREEN, 1, "pre_rst_screen");
    step(1);
    ifa.start = 1'b0;
    step(e0 + 11 - cyc);
    ifa.hit = 1'b1;
    step(1);
    ifa.hit = 1'b0;
    step(2);
    // Between edges: the falling-edge check sees reset values only if the
    // reset acts without a clock edge.
    reset = 1'b0;
    expect_at(cyc, 0, F_SCREEN, 0, "arst_screen");
    expect_at(cyc, 0, F_SCORE,  0, "arst_score");
    expect_at(cyc, 0, F_TIME,   0, "arst_time");
    expect_at(cyc, 0, F_MOLE,   0, "arst_mole");
    step(2);
    reset = 1'b1;
    step(2);

    // Saturation on dut_b: 120 back-to-back hits
    ifb.start = 1'b1;
    e0 = cyc + 1;
    expect_at(e0 + 12,  1, F_SCORE,  exp_score(12), "sat_score12");
    expect_at(e0 + 98,  1, F_SCORE,  exp_score(98), "sat_score98");
    expect_at(e0 + 98,  1, F_SCREEN, 1,             "sat_still_play");
    expect_at(e0 + 99,  1, F_SCORE,  exp_score(99), "sat_score99");
    expect_at(e0 + 99,  1, F_SCREEN, 2,             "sat_screen_win");
    expect_at(e0 + 99,  1, F_WIN,    1,             "sat_win_pulse");
    expect_at(e0 + 100, 1, F_SCORE,  exp_score(99), "sat_score_hold");
    expect_at(e0 + 119, 1, F_SCREEN, 0,             "sat_title");
    expect_at(e0 + 121, 1, F_SCORE,  exp_score(99), "sat_score_final");
    step(1);
    ifb.start = 1'b0;
    ifb.hit   = 1'b1;
    step(120);
    ifb.hit   = 1'b0;
    step(3);

    final_check("pending_expectations", sb.size(), 0);
    final_check("win_pulse_count_a", wins_a, 2);
    final_check("lose_pulse_count_a", loses_a, 1);
    final_check("win_pulse_count_b", wins_b, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
